// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;
  localparam int MAX_NUM_REQ = 16;
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
  function automatic int mod_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick starting the scan at ptr
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
  end
  assign any = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-atomic round-robin sharing of one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          busy,
  output logic [IDX_WIDTH-1:0]          owner
);
  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ out of range");
  end
  state_t               state;
  logic [IDX_WIDTH-1:0] rr_ptr, pick, winner, nxt;
  logic                 any, valid;
  rr_picker #(.N(NUM_REQ), .IW(IDX_WIDTH)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .any(any),
    .idx(pick)
  );
  // gnt is gated by rst so nothing transfers while reset is held
  always_comb begin
    winner   = (state == ST_LOCKED) ? owner : pick;
    valid    = (state == ST_LOCKED) ? req[owner] : any;
    gnt      = (!rst && valid && !fifo_full) ? NUM_REQ'(1) << winner : '0;
    fifo_wr  = |gnt;
    fifo_din = fifo_wr ? req_data[winner*DATA_WIDTH +: DATA_WIDTH] : '0;
    nxt      = IDX_WIDTH'(mod_inc(int'(winner), NUM_REQ));
  end
  assign busy = state == ST_LOCKED;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (fifo_wr) begin
      owner <= winner;
      if (req_last[winner]) begin
        state  <= ST_IDLE;
        rr_ptr <= nxt;
      end else state <= ST_LOCKED;
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with a packet-level reference model
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 32, DEPTH = 8, BEATS = 1024;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0]    req = '0, req_last = '0, gnt;
  logic [N*DW-1:0] req_data = '0;
  logic            fifo_full = 0, fifo_wr, busy;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      owner;
  logic [2:0]      req3 = '0, last3 = '0, gnt3;
  logic [3*DW-1:0] data3 = '0;
  logic            full3 = 0, wr3, busy3;
  logic [DW-1:0]   din3;
  logic [1:0]      owner3;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .gnt(gnt), .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
    .busy(busy), .owner(owner));
  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_last(last3), .req_data(data3),
    .gnt(gnt3), .fifo_full(full3), .fifo_wr(wr3), .fifo_din(din3),
    .busy(busy3), .owner(owner3));

  typedef struct packed {
    logic          wr;
    logic [N-1:0]  gnt;
    logic [DW-1:0] din;
    logic          busy;
    logic [1:0]    owner;
  } exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0;
  logic          mon_wr = 0;
  logic [N-1:0]  mon_gnt = '0;
  logic [DW-1:0] mon_din = '0;
  int m_lock = -1, m_next = 0, m_owner = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // monitor: one expectation per cycle, compared mid-cycle
  initial forever begin
    exp_t e;
    @(negedge clk);
    mon_wr = fifo_wr; mon_gnt = gnt; mon_din = fifo_din;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("fifo_wr", 32'(fifo_wr), 32'(e.wr));
      chk("fifo_din", fifo_din, e.din);
      chk("busy", 32'(busy), 32'(e.busy));
      chk("owner", 32'(owner), 32'(e.owner));
    end
  end

  // drive one cycle and predict it: a locked port serves only its holder,
  // otherwise the first requester at or after the round-robin start wins
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*DW-1:0] d,
                      input logic f, input logic rs);
    exp_t e;
    int w;
    w = -1;
    e = '0;
    rst = rs; req = r; req_last = l; req_data = d; fifo_full = f;
    if (rs) begin
      m_lock = -1; m_next = 0; m_owner = 0;
    end else begin
      e.busy  = m_lock >= 0;
      e.owner = 2'(m_owner);
      if (!f) begin
        if (m_lock >= 0) begin
          if (r[m_lock]) w = m_lock;
        end else
          for (int k = 0; k < N; k++) if (w < 0 && r[(m_next + k) % N]) w = (m_next + k) % N;
      end
      if (w >= 0) begin
        e.wr  = 1;
        e.gnt = N'(1 << w);
        e.din = d[w*DW +: DW];
        m_owner = w;
        if (l[w]) begin
          m_lock = -1;
          m_next = (w + 1) % N;
        end else m_lock = w;
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  function automatic logic [N*DW-1:0] pk(input logic [DW-1:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  int act[N], rem[N], seq[N], exp_seq[N];
  logic [DW-1:0] fq[$];
  int open = -1, pops = 0, e2e_bad = 0, cyc = 0;
  logic [3:0] exp3[4] = '{4'b001, 4'b010, 4'b100, 4'b001};

  initial begin
    logic [N-1:0] r, l;
    logic [N*DW-1:0] d;
    logic [DW-1:0] beat;
    int p, e0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) step('1, '1, pk('h10, 'h11, 'h12, 'h13), 0, 1);
    for (int k = 0; k < 8; k++) step('1, '1, pk('h10, 'h11, 'h12, 'h13), 0, 0);
    step(4'b0100, 4'b0000, pk(0, 0, 'hA0, 0), 0, 0);
    step(4'b1101, 4'b0000, pk('h50, 0, 'hA1, 'h53), 0, 0);
    step(4'b1101, 4'b0100, pk('h50, 0, 'hA2, 'h53), 0, 0);
    step(4'b1001, 4'b1001, pk('h50, 0, 0, 'h53), 0, 0);
    step(4'b0010, 4'b0000, pk(0, 'hB0, 0, 0), 0, 0);
    for (int k = 0; k < 5; k++) step(4'b0011, 4'b0001, pk('h50, 'hB1, 0, 0), 1, 0);
    step(4'b0011, 4'b0001, pk('h50, 'hB1, 0, 0), 0, 0);
    step(4'b0011, 4'b0011, pk('h50, 'hB2, 0, 0), 0, 0);
    step(4'b0001, 4'b0001, pk('h50, 0, 0, 0), 0, 0);
    step(4'b0100, 4'b0000, pk(0, 0, 'hC0, 0), 0, 0);
    for (int k = 0; k < 3; k++) step(4'b1001, 4'b1001, pk('h50, 0, 0, 'h53), 0, 0);
    step(4'b0100, 4'b0100, pk(0, 0, 'hC1, 0), 0, 0);
    step('0, '0, '0, 0, 0);
    // three-producer instance: rr pointer must wrap from 2 back to 0
    req3 = 3'b100; last3 = 3'b100; data3 = {32'h32, 32'h31, 32'h30};
    @(negedge clk);
    chk("n3_first_gnt", 32'(gnt3), 32'b100);
    chk("n3_first_din", din3, 32'h32);
    @(posedge clk); #1;
    req3 = 3'b111; last3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("n3_wrap_gnt", 32'(gnt3), 32'(exp3[k]));
      @(posedge clk); #1;
    end
    req3 = '0;
    // randomized run through a modelled FIFO with a random consumer
    step('0, '0, '0, 0, 1);
    for (int i = 0; i < N; i++) begin act[i] = 0; rem[i] = 0; seq[i] = 0; exp_seq[i] = 0; end
    while (pops < BEATS && cyc < 20000) begin
      cyc++;
      for (int i = 0; i < N; i++)
        if (mon_gnt[i]) begin
          seq[i]++; rem[i]--;
          act[i] = (rem[i] == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3) != 0);
          if (act[i] != 0 && rem[i] == 0) rem[i] = $urandom_range(1, 4);
        end else if (act[i] == 0 && $urandom_range(0, 2) == 0) begin
          act[i] = 1;
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
        end
      if (fq.size() > 0 && $urandom_range(0, 2) != 0) begin
        beat = fq.pop_front();
        p = int'(beat[25:24]);
        e0 = errors;
        chk("order_seq", 32'(beat[15:0]), 32'(exp_seq[p] & 'hffff));
        if (open >= 0) chk("contiguous", 32'(p), 32'(open));
        if (errors > e0) e2e_bad++;
        exp_seq[p]++;
        open = beat[31] ? -1 : p;
        pops++;
      end
      if (mon_wr) fq.push_back(mon_din);
      for (int i = 0; i < N; i++) begin
        r[i] = act[i] != 0;
        l[i] = rem[i] == 1;
        d[i*DW +: DW] = {l[i], 5'b0, 2'(i), 8'h0, 16'(seq[i])};
      end
      step(r, l, d, fq.size() >= DEPTH, 0);
    end
    if (pops < BEATS) begin
      checks++; errors++;
      $display("FAIL budget: popped %0d beats want %0d", pops, BEATS);
    end
    chk("queue_drained", 32'(exp_q.size()), 0);
    if (e2e_bad == 0) $display("[PASS] fifo order: %0d beats popped", pops);
    else $display("[FAIL] fifo order: %0d bad pops, want 0", e2e_bad);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one `fifo` instance (DATA_WIDTH, LOOKAHEAD=1) among NUM_REQ producers.
- Arbitration is round-robin, one packet at a time. A granted producer holds the port until it writes the beat flagged last, so packets never interleave in the FIFO.
- Sits directly in front of `fifo.wr`/`fifo.din`/`fifo.full`. The read side of the FIFO is untouched.

Parameters:
- NUM_REQ, 4, number of producers; legal range 2..16.
- DATA_WIDTH, 32, beat width; must equal the FIFO's DATA_WIDTH.
- IDX_WIDTH, $clog2(NUM_REQ), width of the owner index (derived; do not override).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NUM_REQ  per-producer valid; bit i = producer i has a beat.
- req_last  input  NUM_REQ  bit i = producer i's current beat ends its packet.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened beats; producer i at [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  per-producer ready; a beat transfers when req[i] && gnt[i].
- fifo_full  input  1  from fifo.full.
- fifo_wr  output  1  to fifo.wr.
- fifo_din  output  DATA_WIDTH  to fifo.din.
- busy  output  1  1 while a packet is locked (state LOCKED).
- owner  output  IDX_WIDTH  index of the current/last granted producer.

Behaviour:
- State: two-state FSM (IDLE, LOCKED) plus registers `owner` and `rr_ptr`.
- Reset: while rst=1, state=IDLE, owner=0, rr_ptr=0; gnt=0, fifo_wr=0, fifo_din=0, busy=0, irrespective of req.
- Reset mid-packet: the partial packet is abandoned with no flush. The FIFO reset is the system's responsibility.
- Winner selection:
  - IDLE: winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - LOCKED: winner = owner; a request from any other producer is ignored.
- Grant and write (combinational):
  - gnt[winner] = req[winner] && !fifo_full; every other gnt bit is 0.
  - gnt is one-hot or zero in every cycle.
  - fifo_wr = |gnt; fifo_din = req_data slice of the winner.
  - When fifo_wr=0, fifo_din = 0.
  - Latency 0: a beat presented in cycle t is written to the FIFO at the end of cycle t.
- Transitions (posedge, only when fifo_wr=1):
  - IDLE with !req_last[winner]: state→LOCKED, owner←winner.
  - IDLE with req_last[winner]: single-beat packet; stay IDLE, owner←winner, rr_ptr←winner+1 (mod NUM_REQ).
  - LOCKED with req_last[owner]: state→IDLE, rr_ptr←owner+1 (mod NUM_REQ).
  - LOCKED with !req_last[owner]: stay LOCKED.
- No-transfer cycle (fifo_wr=0): state, owner and rr_ptr hold.
- FIFO full: while fifo_full=1, gnt=0 and nothing changes. A producer holding req is served in the first cycle fifo_full drops; there is no skip.
- Owner drops req mid-packet: the port stays locked and idles. No timeout, no preemption.
- Modulo wrap: if NUM_REQ is not a power of two, rr_ptr=NUM_REQ-1 plus 1 wraps to 0, never to NUM_REQ.
- Fairness: a continuously requesting producer waits at most NUM_REQ-1 packets.
- busy = (state==LOCKED). owner is held after the packet ends.
- Producer contract: req, req_last and the data slice stay stable until gnt. The arbiter does not check this.

Decomposition:
- Package fifo_arb_pkg:
  - state enum (ST_IDLE, ST_LOCKED);
  - function for the modulo-NUM_REQ increment;
  - constant MAX_NUM_REQ=16.
- Sub-module rr_picker:
  - inputs: req vector, rr_ptr;
  - outputs: `any` and winner index;
  - purely combinational rotate, priority-encode, un-rotate.
- Top module: FSM, registers and data mux.

Test Plan:
- Reset with req=4'b1111 held → gnt=0, fifo_wr=0 throughout reset. After release, the first grant goes to producer 0; rr_ptr=1 after that producer's single-beat packet.
- All four producers send single-beat packets continuously (data 'h10+i) → FIFO receives 'h10,'h11,'h12,'h13,'h10… with one beat per cycle.
- Producer 2 sends 3 beats 'hA0,'hA1,'hA2 (last on the third) while producers 0 and 3 request:
  - FIFO holds 'hA0..'hA2 contiguously, busy=1 for 2 cycles, and producer 3 wins next.
- fifo_full forced high for 5 cycles in the middle of producer 1's packet → gnt=0 and no write in those cycles. Resumes the same packet with no lost or duplicated beat; producer 0's request is ignored until last.
- NUM_REQ=3: producer 2 finishes, then all three request → producer 0 wins (rr_ptr wraps to 0).
- Scoreboard run mirroring the FIFO bench:
  - Random req/last, random consumer rd against the LOOKAHEAD FIFO, 1024 beats.
  - Per-producer order is preserved and packets are contiguous; print [PASS]/[FAIL].
